chunked_adder_fi: RTL and testbench

- Parametrised multi-cycle ripple-carry adder. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, with a carry register between chunks.
- Built-in fault injection: one full-adder cell, selected at run time, can be made defective.
- Built-in golden-reference comparator flags when the produced sum is wrong.
- Used as the fault-detection test vehicle for the adder experiments. It replaces fixed-width combinational chains that have a hard-wired faulty cell.

---
 rtl/chunked_adder_fi.sv | 194 +++++++++++++++++++
 tb/tb_chunked_adder_fi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder_fi.sv
// chunked_adder_fi
// Multi-cycle ripple-carry adder that evaluates CHUNK full-adder cells per
// clock, keeping a carry register between chunks. One cell can be made
// defective at run time, and the result is compared against the exact sum
// of the latched operands.
module chunked_adder_fi #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   cin,
    input  logic [1:0]             fault_mode,
    input  logic [$clog2(WIDTH):0] fault_bit,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH:0]         sum,
    output logic                   mismatch
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int FBW    = $clog2(WIDTH) + 1;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-adder cell. When inj is set the cell misbehaves as selected
    // by mode: inverted sum, or carry-out stuck at 0 or 1. Returns {co, s}.
    function automatic logic [1:0] fa_cell(input logic ai, input logic bi,
                                           input logic ci, input logic inj,
                                           input logic [1:0] mode);
        logic s;
        logic co;
        s  = ai ^ bi ^ ci;
        co = (ai & bi) | (ai & ci) | (bi & ci);
        if (inj) begin
            case (mode)
                2'b01:   s  = ~s;
                2'b10:   co = 1'b0;
                2'b11:   co = 1'b1;
                default: s  = s;
            endcase
        end else begin
            s = s;
        end
        return {co, s};
    endfunction

    state_t            state_r, state_nx;
    logic [KW-1:0]     k_r, k_nx;
    logic              carry_r, carry_nx;
    logic [WIDTH-1:0]  a_r, a_nx, b_r, b_nx;
    logic              cin_r, cin_nx;
    logic [1:0]        mode_r, mode_nx;
    logic [FBW-1:0]    fbit_r, fbit_nx;
    logic              busy_r, busy_nx, done_r, done_nx;
    logic [WIDTH:0]    sum_r, sum_nx;
    logic              mismatch_r, mismatch_nx;

    logic [CHUNK-1:0]  a_chunk_s, b_chunk_s, chunk_sum_s;
    logic              ripple_s;
    logic [1:0]        cell_s;
    logic [FBW-1:0]    cell_idx_s;
    logic [WIDTH:0]    sum_merge_s, sum_final_s, exact_s;
    logic              accept_s, last_s;

    // Ripple the current chunk from the carry register through CHUNK cells.
    always_comb begin
        a_chunk_s   = CHUNK'(a_r >> (k_r * CHUNK));
        b_chunk_s   = CHUNK'(b_r >> (k_r * CHUNK));
        chunk_sum_s = {CHUNK{1'b0}};
        ripple_s    = carry_r;
        cell_s      = 2'b00;
        cell_idx_s  = {FBW{1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            cell_idx_s     = FBW'(int'(k_r) * CHUNK + i);
            cell_s         = fa_cell(a_chunk_s[i], b_chunk_s[i], ripple_s,
                                     (mode_r != 2'b00) && (fbit_r == cell_idx_s),
                                     mode_r);
            chunk_sum_s[i] = cell_s[0];
            ripple_s       = cell_s[1];
        end
    end

    // Merge the chunk into the running sum and form the exact reference.
    always_comb begin
        sum_merge_s = (sum_r & ~((WIDTH+1)'({CHUNK{1'b1}}) << (k_r * CHUNK)))
                    | ((WIDTH+1)'(chunk_sum_s) << (k_r * CHUNK));
        sum_final_s = {ripple_s, sum_merge_s[WIDTH-1:0]};
        exact_s     = (WIDTH+1)'(a_r) + (WIDTH+1)'(b_r) + (WIDTH+1)'(cin_r);
        accept_s    = start && ((state_r == IDLE) || (state_r == DONE));
        last_s      = (k_r == KW'(NCHUNK - 1));
    end

    // Next-state and next-output logic of the control FSM.
    always_comb begin
        state_nx    = state_r;
        k_nx        = k_r;
        carry_nx    = carry_r;
        a_nx        = a_r;
        b_nx        = b_r;
        cin_nx      = cin_r;
        mode_nx     = mode_r;
        fbit_nx     = fbit_r;
        busy_nx     = busy_r;
        done_nx     = 1'b0;
        sum_nx      = sum_r;
        mismatch_nx = mismatch_r;
        if (accept_s) begin
            state_nx    = ADD;
            k_nx        = {KW{1'b0}};
            carry_nx    = cin;
            a_nx        = a;
            b_nx        = b;
            cin_nx      = cin;
            mode_nx     = fault_mode;
            fbit_nx     = fault_bit;
            busy_nx     = 1'b1;
            sum_nx      = {(WIDTH+1){1'b0}};
            mismatch_nx = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx = IDLE;
                end
                ADD: begin
                    carry_nx = ripple_s;
                    if (last_s) begin
                        sum_nx      = sum_final_s;
                        mismatch_nx = (sum_final_s != exact_s);
                        state_nx    = DONE;
                        busy_nx     = 1'b0;
                        done_nx     = 1'b1;
                        k_nx        = {KW{1'b0}};
                    end else begin
                        sum_nx = sum_merge_s;
                        k_nx   = k_r + KW'(1'b1);
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            k_r        <= {KW{1'b0}};
            carry_r    <= 1'b0;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            cin_r      <= 1'b0;
            mode_r     <= 2'b00;
            fbit_r     <= {FBW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sum_r      <= {(WIDTH+1){1'b0}};
            mismatch_r <= 1'b0;
        end else begin
            state_r    <= state_nx;
            k_r        <= k_nx;
            carry_r    <= carry_nx;
            a_r        <= a_nx;
            b_r        <= b_nx;
            cin_r      <= cin_nx;
            mode_r     <= mode_nx;
            fbit_r     <= fbit_nx;
            busy_r     <= busy_nx;
            done_r     <= done_nx;
            sum_r      <= sum_nx;
            mismatch_r <= mismatch_nx;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign mismatch = mismatch_r;

endmodule

// File: tb/tb_chunked_adder_fi.sv
// Directed testbench for chunked_adder_fi (WIDTH=8, CHUNK=2).
module tb_chunked_adder_fi;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] fault_mode;
    logic [3:0] fault_bit;
    logic       busy;
    logic       done;
    logic [8:0] sum;
    logic       mismatch;

    int checks = 0;
    int errors = 0;

    chunked_adder_fi #(.WIDTH(8), .CHUNK(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .fault_mode (fault_mode),
        .fault_bit  (fault_bit),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .mismatch   (mismatch)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for exactly one rising edge; returns at the
    // falling edge following the start-sampling edge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic ic, input logic [1:0] im,
                         input logic [3:0] ifb);
        @(negedge clk);
        a = ia; b = ib; cin = ic; fault_mode = im; fault_bit = ifb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step falling edges until done, bounded; n = edges waited, bc = busy samples.
    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b0;
        fault_mode = 2'b00; fault_bit = 4'd0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sum !== 9'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_add();
        logic [7:0] ta [3] = '{8'd100, 8'd255, 8'd255};
        logic [7:0] tb [3] = '{8'd27, 8'd1, 8'd255};
        logic       tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [8:0] ts [3] = '{9'd127, 9'h101, 9'd511};
        int n, bc;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], tc[i], 2'b00, 4'd0);
            wait_done(n, bc);
            checks++; if (n !== 4) begin errors++; $display("FAIL add%0d_latency got %0d want 4", i, n); end
            checks++; if (bc !== 4) begin errors++; $display("FAIL add%0d_busy_cycles got %0d want 4", i, bc); end
            checks++; if (sum !== ts[i]) begin errors++; $display("FAIL add%0d_sum got %0d want %0d", i, sum, ts[i]); end
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL add%0d_mismatch got %b want 0", i, mismatch); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL add%0d_done_pulse got %b want 0", i, done); end
            checks++; if (sum !== ts[i]) begin errors++; $display("FAIL add%0d_sum_hold got %0d want %0d", i, sum, ts[i]); end
        end
    endtask

    task automatic test_faults();
        logic [7:0] ta [4] = '{8'd100, 8'd100, 8'd1, 8'd0};
        logic [7:0] tb [4] = '{8'd27, 8'd27, 8'd1, 8'd0};
        logic [1:0] tm [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic [3:0] tf [4] = '{4'd7, 4'd9, 4'd0, 4'd1};
        logic [8:0] ts [4] = '{9'd255, 9'd127, 9'd0, 9'd4};
        logic       tx [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int n, bc;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], 1'b0, tm[i], tf[i]);
            wait_done(n, bc);
            checks++; if (n !== 4) begin errors++; $display("FAIL fault%0d_latency got %0d want 4", i, n); end
            checks++; if (sum !== ts[i]) begin errors++; $display("FAIL fault%0d_sum got %0d want %0d", i, sum, ts[i]); end
            checks++; if (mismatch !== tx[i]) begin errors++; $display("FAIL fault%0d_mismatch got %b want %b", i, mismatch, tx[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n, bc, n2;
        @(negedge clk);
        a = 8'd100; b = 8'd27; cin = 1'b0; fault_mode = 2'b00; fault_bit = 4'd0;
        start = 1'b1;
        wait_done(n, bc);
        checks++; if (sum !== 9'd127) begin errors++; $display("FAIL b2b_first_sum got %0d want 127", sum); end
        a = 8'd10; b = 8'd5; cin = 1'b1;
        n2 = 0;
        do begin
            @(negedge clk);
            n2++;
        end while (done !== 1'b1 && n2 < 20);
        start = 1'b0;
        checks++; if (n2 !== 5) begin errors++; $display("FAIL b2b_period got %0d want 5", n2); end
        checks++; if (sum !== 9'd16) begin errors++; $display("FAIL b2b_second_sum got %0d want 16", sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL b2b_mismatch got %b want 0", mismatch); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_ignored_start();
        int n, bc;
        issue(8'd100, 8'd27, 1'b0, 2'b00, 4'd0);
        @(negedge clk);
        a = 8'd1; b = 8'd1; cin = 1'b1; fault_mode = 2'b01; fault_bit = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        checks++; if (n !== 2) begin errors++; $display("FAIL ign_latency got %0d want 2", n); end
        checks++; if (sum !== 9'd127) begin errors++; $display("FAIL ign_sum got %0d want 127", sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL ign_mismatch got %b want 0", mismatch); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_not_queued got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int n, bc;
        issue(8'd255, 8'd255, 1'b1, 2'b00, 4'd0);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy_before got %b want 1", busy); end
        checks++; if (sum !== 9'h00F) begin errors++; $display("FAIL ar_partial_sum got %0d want 15", sum); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ar_done got %b want 0", done); end
        checks++; if (sum !== 9'd0) begin errors++; $display("FAIL ar_sum got %0d want 0", sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL ar_mismatch got %b want 0", mismatch); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_discarded got %b want 0", busy); end
        issue(8'd10, 8'd5, 1'b1, 2'b00, 4'd0);
        wait_done(n, bc);
        checks++; if (n !== 4) begin errors++; $display("FAIL ar_post_latency got %0d want 4", n); end
        checks++; if (sum !== 9'd16) begin errors++; $display("FAIL ar_post_sum got %0d want 16", sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL ar_post_mismatch got %b want 0", mismatch); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_faults();
        test_back_to_back();
        test_ignored_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
